alarm_trigger: RTL and testbench

ALARM_TRIGGER -- requirements
Module: alarm_trigger

---
 rtl/alarm_trigger.sv | 137 +++++++++++++
 tb/tb_alarm_trigger.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger.sv
// Alarm trigger: detects the HH:MM:00 match against the stored alarm time and
// runs the ring / snooze / auto-silence sequence that drives the buzzer.
module alarm_trigger #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic [1:0] c_hour1,
    input  logic [3:0] c_hour0,
    input  logic [3:0] c_min1,
    input  logic [3:0] c_min0,
    input  logic [3:0] c_sec1,
    input  logic [3:0] c_sec0,
    input  logic [1:0] a_hour1,
    input  logic [3:0] a_hour0,
    input  logic [3:0] a_min1,
    input  logic [3:0] a_min0,
    input  logic       AL_ON,
    input  logic       STOP_al,
    input  logic       SNOOZE,
    output logic       Alarm,
    output logic       snooze_active
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE
    } state_t;

    localparam logic [9:0] RING_LAST    = 10'(RING_SEC - 1);
    localparam logic [9:0] SNOOZE_LAST  = 10'(SNOOZE_SEC - 1);
    localparam logic [1:0] SNOOZE_LIMIT = 2'(MAX_SNOOZE);

    state_t     state_q, state_d;
    logic [9:0] sec_cnt_q, sec_cnt_d;
    logic [1:0] snooze_cnt_q, snooze_cnt_d;
    logic       snooze_lock_q, snooze_lock_d;
    logic       match_now, match_prev, trigger;
    logic       cancel, snooze_req;

    assign match_now = (c_hour1 == a_hour1) && (c_hour0 == a_hour0) &&
                       (c_min1 == a_min1) && (c_min0 == a_min0) &&
                       (c_sec1 == 4'd0) && (c_sec0 == 4'd0);
    assign trigger   = match_now && !match_prev;

    assign cancel = !AL_ON || STOP_al;
    // A held snooze button is honoured once; it must be released before it counts again.
    assign snooze_req = SNOOZE && !snooze_lock_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            sec_cnt_q     <= '0;
            snooze_cnt_q  <= '0;
            snooze_lock_q <= 1'b0;
            match_prev    <= 1'b1;
        end else begin
            state_q       <= state_d;
            sec_cnt_q     <= sec_cnt_d;
            snooze_cnt_q  <= snooze_cnt_d;
            snooze_lock_q <= snooze_lock_d;
            match_prev    <= match_now;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        sec_cnt_d     = sec_cnt_q;
        snooze_cnt_d  = snooze_cnt_q;
        snooze_lock_d = snooze_lock_q && SNOOZE;

        case (state_q)
            ST_IDLE: begin
                sec_cnt_d    = '0;
                snooze_cnt_d = '0;
                if (trigger && AL_ON) begin
                    state_d = ST_RING;
                end
            end

            ST_RING: begin
                if (cancel) begin
                    state_d      = ST_IDLE;
                    sec_cnt_d    = '0;
                    snooze_cnt_d = '0;
                end else if (snooze_req && (snooze_cnt_q < SNOOZE_LIMIT)) begin
                    state_d       = ST_SNOOZE;
                    sec_cnt_d     = '0;
                    snooze_cnt_d  = snooze_cnt_q + 2'd1;
                    snooze_lock_d = 1'b1;
                end else if (tick_1s) begin
                    if (sec_cnt_q == RING_LAST) begin
                        state_d      = ST_IDLE;
                        sec_cnt_d    = '0;
                        snooze_cnt_d = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 10'd1;
                    end
                end
            end

            ST_SNOOZE: begin
                if (cancel) begin
                    state_d      = ST_IDLE;
                    sec_cnt_d    = '0;
                    snooze_cnt_d = '0;
                end else if (tick_1s) begin
                    if (sec_cnt_q == SNOOZE_LAST) begin
                        state_d   = ST_RING;
                        sec_cnt_d = '0;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 10'd1;
                    end
                end
            end

            default: begin
                state_d      = ST_IDLE;
                sec_cnt_d    = '0;
                snooze_cnt_d = '0;
            end
        endcase
    end

    // Decoded straight from the state register, so reset silences them at once.
    assign Alarm         = (state_q == ST_RING);
    assign snooze_active = (state_q == ST_SNOOZE);

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: scripted time-of-day stimulus with a
// scoreboard of expected {Alarm, snooze_active} values checked after each edge.
module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1s;
    logic [1:0] c_hour1;
    logic [3:0] c_hour0, c_min1, c_min0, c_sec1, c_sec0;
    logic [1:0] a_hour1;
    logic [3:0] a_hour0, a_min1, a_min0;
    logic       AL_ON, STOP_al, SNOOZE;
    logic       Alarm, snooze_active;

    localparam logic [1:0] OUT_IDLE   = 2'b00;
    localparam logic [1:0] OUT_RING   = 2'b10;
    localparam logic [1:0] OUT_SNOOZE = 2'b01;

    typedef struct {
        string      tag;
        logic [1:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       tod   = 0;

    alarm_trigger dut (
        .clk          (clk),
        .reset        (reset),
        .tick_1s      (tick_1s),
        .c_hour1      (c_hour1),
        .c_hour0      (c_hour0),
        .c_min1       (c_min1),
        .c_min0       (c_min0),
        .c_sec1       (c_sec1),
        .c_sec0       (c_sec0),
        .a_hour1      (a_hour1),
        .a_hour0      (a_hour0),
        .a_min1       (a_min1),
        .a_min0       (a_min0),
        .AL_ON        (AL_ON),
        .STOP_al      (STOP_al),
        .SNOOZE       (SNOOZE),
        .Alarm        (Alarm),
        .snooze_active(snooze_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: {Alarm,snooze_active} got %b, expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    task automatic apply_time();
        int h, m, s;
        h = tod / 3600;
        m = (tod / 60) % 60;
        s = tod % 60;
        c_hour1 = 2'(h / 10);
        c_hour0 = 4'(h % 10);
        c_min1  = 4'(m / 10);
        c_min0  = 4'(m % 10);
        c_sec1  = 4'(s / 10);
        c_sec0  = 4'(s % 10);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic compare_out();
        sb_item_t it;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 2'b00, 2'b11);
        end else begin
            it = sb.pop_front();
            check(it.tag, {Alarm, snooze_active}, it.exp);
        end
    endtask

    // One clock: inputs change at the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic step(input logic tk, input logic stp, input logic snz,
                        input logic [1:0] exp, input string tag);
        @(negedge clk);
        tick_1s = tk;
        STOP_al = stp;
        SNOOZE  = snz;
        if (tk) tod = (tod + 1) % 86400;
        apply_time();
        expect_out(tag, exp);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic ticks(input int n, input logic snz, input logic [1:0] exp, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, snz, exp, tag);
    endtask

    task automatic do_reset(input int t);
        @(negedge clk);
        reset   = 1'b1;
        tick_1s = 1'b0;
        STOP_al = 1'b0;
        SNOOZE  = 1'b0;
        tod     = t;
        apply_time();
        @(posedge clk);
        #1;
        expect_out("reset_hold", OUT_IDLE);
        compare_out();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        tick_1s = 1'b0;
        STOP_al = 1'b0;
        SNOOZE  = 1'b0;
        AL_ON   = 1'b1;
        a_hour1 = 2'd0;
        a_hour0 = 4'd7;
        a_min1  = 4'd3;
        a_min0  = 4'd0;
        apply_time();

        // Basic ring and auto-silence after 60 ticks.
        do_reset(hms(7, 29, 50));
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "pre_match");
        ticks(9, 1'b0, OUT_IDLE, "approach");
        ticks(1, 1'b0, OUT_RING, "ring_rise");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, OUT_RING, "ring_hold");
        ticks(59, 1'b0, OUT_RING, "ring_count");
        ticks(1, 1'b0, OUT_IDLE, "ring_timeout");
        ticks(2, 1'b0, OUT_IDLE, "after_timeout");

        // Alarm disabled: the matching minute passes silently.
        AL_ON = 1'b0;
        tod   = hms(7, 29, 59);
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "off_pre");
        ticks(1, 1'b0, OUT_IDLE, "off_match");
        ticks(59, 1'b0, OUT_IDLE, "off_minute");
        AL_ON = 1'b1;
        ticks(2, 1'b0, OUT_IDLE, "off_reenabled");

        // Three full snooze cycles, the first with SNOOZE held through expiry.
        tod = hms(7, 29, 59);
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "s_pre");
        ticks(1, 1'b0, OUT_RING, "s_ring");
        ticks(5, 1'b0, OUT_RING, "s_ring_count");
        for (int n = 1; n <= 3; n++) begin
            logic hold;
            hold = (n == 1);
            step(1'b0, 1'b0, 1'b1, OUT_SNOOZE, "snooze_press");
            ticks(299, hold, OUT_SNOOZE, "snooze_wait");
            ticks(1, hold, OUT_RING, "snooze_expire");
            if (hold) step(1'b0, 1'b0, 1'b1, OUT_RING, "snooze_held_once");
            step(1'b0, 1'b0, 1'b0, OUT_RING, "snooze_release");
        end
        step(1'b0, 1'b0, 1'b1, OUT_RING, "snooze4_ignored");
        step(1'b0, 1'b0, 1'b0, OUT_RING, "snooze4_release");
        ticks(3, 1'b0, OUT_RING, "ring_after_max");
        step(1'b0, 1'b1, 1'b0, OUT_IDLE, "stop");
        step(1'b0, 1'b1, 1'b0, OUT_IDLE, "stop_held");
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "stop_release");

        // Reset released past the matching second: no ring until the next day.
        do_reset(hms(7, 30, 5));
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "rst_late_release");
        ticks(20, 1'b0, OUT_IDLE, "rst_late_run");
        tod = hms(7, 29, 59);
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "next_day_pre");
        ticks(1, 1'b0, OUT_RING, "next_day_ring");

        // Asynchronous reset mid-ring, released while time still equals the alarm.
        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset", OUT_IDLE);
        compare_out();
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "rst_release_on_match");
        ticks(2, 1'b0, OUT_IDLE, "rst_release_run");

        // After reset the sequence starts from clean counters.
        tod = hms(7, 29, 59);
        step(1'b0, 1'b0, 1'b0, OUT_IDLE, "post_rst_pre");
        ticks(1, 1'b0, OUT_RING, "post_rst_ring");
        step(1'b0, 1'b0, 1'b1, OUT_SNOOZE, "post_rst_snooze");
        step(1'b0, 1'b0, 1'b0, OUT_SNOOZE, "post_rst_snooze_hold");
        step(1'b0, 1'b1, 1'b0, OUT_IDLE, "stop_in_snooze");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
